// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at issue, collects CDB results,
// answers operand queries, commits in order and flushes on branch mispredict.
module reorder_buffer #(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    input  logic             issue_pred_taken,
    input  logic [31:0]      issue_alt_pc,
    output logic             rob_full,
    output logic [ROB_W-1:0] issue_rob_id,
    output logic             need_set_reg_dep,
    output logic [4:0]       set_dep_reg_id,
    output logic [ROB_W-1:0] set_dep_rob_id,
    input  logic             alu_wb_valid,
    input  logic [ROB_W-1:0] alu_wb_rob_id,
    input  logic [31:0]      alu_wb_value,
    input  logic             alu_wb_taken,
    input  logic             lsb_wb_valid,
    input  logic [ROB_W-1:0] lsb_wb_rob_id,
    input  logic [31:0]      lsb_wb_value,
    input  logic [ROB_W-1:0] need_rob_id1,
    input  logic [ROB_W-1:0] need_rob_id2,
    output logic             rob_value1_ready,
    output logic             rob_value2_ready,
    output logic [31:0]      rob_value1,
    output logic [31:0]      rob_value2,
    output logic             need_set_reg_value,
    output logic [4:0]       set_value_reg_id,
    output logic [31:0]      set_val,
    output logic [ROB_W-1:0] set_reg_rob_id,
    output logic             store_commit,
    output logic [ROB_W-1:0] store_commit_rob_id,
    output logic             clear,
    output logic [31:0]      clear_pc
);

    localparam int DEPTH = 1 << ROB_W;
    localparam logic [ROB_W:0] DEPTH_CNT = (ROB_W + 1)'(DEPTH);
    localparam logic [1:0] T_ALU    = 2'd0;
    localparam logic [1:0] T_LOAD   = 2'd1;
    localparam logic [1:0] T_STORE  = 2'd2;
    localparam logic [1:0] T_BRANCH = 2'd3;

    logic             ent_busy  [DEPTH];
    logic             ent_ready [DEPTH];
    logic [1:0]       ent_type  [DEPTH];
    logic [4:0]       ent_rd    [DEPTH];
    logic             ent_pred  [DEPTH];
    logic             ent_taken [DEPTH];
    logic [31:0]      ent_alt   [DEPTH];
    logic [31:0]      ent_value [DEPTH];

    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [ROB_W:0]   count;

    logic issue_fire;
    logic commit_fire;
    logic mispredict;
    logic alu_wb_fire;
    logic lsb_wb_fire;

    assign rob_full     = (count == DEPTH_CNT) || clear;
    assign issue_fire   = rdy && issue_valid && !rob_full;
    assign commit_fire  = rdy && (count != '0) && ent_ready[head];
    assign mispredict   = commit_fire && (ent_type[head] == T_BRANCH) &&
                          (ent_taken[head] != ent_pred[head]);
    assign alu_wb_fire  = rdy && !clear && alu_wb_valid && ent_busy[alu_wb_rob_id];
    assign lsb_wb_fire  = rdy && !clear && lsb_wb_valid && ent_busy[lsb_wb_rob_id];

    assign issue_rob_id     = tail;
    assign need_set_reg_dep = issue_fire && (issue_rd != 5'd0);
    assign set_dep_reg_id   = issue_rd;
    assign set_dep_rob_id   = tail;

    // Stored result first, then same-cycle ALU bypass, then LSB bypass.
    function automatic logic [32:0] lookup(input logic [ROB_W-1:0] id);
        logic [32:0] r;
        r = '0;
        if (ent_ready[id])
            r = {1'b1, ent_value[id]};
        else if (alu_wb_valid && alu_wb_rob_id == id)
            r = {1'b1, alu_wb_value};
        else if (lsb_wb_valid && lsb_wb_rob_id == id)
            r = {1'b1, lsb_wb_value};
        return r;
    endfunction

    always_comb begin
        {rob_value1_ready, rob_value1} = lookup(need_rob_id1);
        {rob_value2_ready, rob_value2} = lookup(need_rob_id2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            need_set_reg_value  <= 1'b0;
            set_value_reg_id    <= '0;
            set_val             <= '0;
            set_reg_rob_id      <= '0;
            store_commit        <= 1'b0;
            store_commit_rob_id <= '0;
            clear               <= 1'b0;
            clear_pc            <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_busy[i]  <= 1'b0;
                ent_ready[i] <= 1'b0;
                ent_type[i]  <= '0;
                ent_rd[i]    <= '0;
                ent_pred[i]  <= 1'b0;
                ent_taken[i] <= 1'b0;
                ent_alt[i]   <= '0;
                ent_value[i] <= '0;
            end
        end else if (rdy) begin
            need_set_reg_value  <= 1'b0;
            set_value_reg_id    <= '0;
            set_val             <= '0;
            set_reg_rob_id      <= '0;
            store_commit        <= 1'b0;
            store_commit_rob_id <= '0;
            clear               <= 1'b0;

            if (mispredict) begin
                // Everything younger than the branch is wrong-path work.
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                clear    <= 1'b1;
                clear_pc <= ent_alt[head];
                for (int i = 0; i < DEPTH; i++) begin
                    ent_busy[i]  <= 1'b0;
                    ent_ready[i] <= 1'b0;
                end
            end else begin
                if (alu_wb_fire) begin
                    ent_value[alu_wb_rob_id] <= alu_wb_value;
                    ent_taken[alu_wb_rob_id] <= alu_wb_taken;
                    ent_ready[alu_wb_rob_id] <= 1'b1;
                end
                if (lsb_wb_fire) begin
                    ent_value[lsb_wb_rob_id] <= lsb_wb_value;
                    ent_ready[lsb_wb_rob_id] <= 1'b1;
                end

                if (commit_fire) begin
                    ent_busy[head]  <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                    if ((ent_type[head] == T_ALU || ent_type[head] == T_LOAD) &&
                        ent_rd[head] != 5'd0) begin
                        need_set_reg_value <= 1'b1;
                        set_value_reg_id   <= ent_rd[head];
                        set_val            <= ent_value[head];
                        set_reg_rob_id     <= head;
                    end
                    if (ent_type[head] == T_STORE) begin
                        store_commit        <= 1'b1;
                        store_commit_rob_id <= head;
                    end
                end

                if (issue_fire) begin
                    ent_busy[tail]  <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    ent_type[tail]  <= issue_type;
                    ent_rd[tail]    <= issue_rd;
                    ent_pred[tail]  <= issue_pred_taken;
                    ent_taken[tail] <= 1'b0;
                    ent_alt[tail]   <= issue_alt_pc;
                    tail            <= tail + 1'b1;
                end

                if (issue_fire && !commit_fire)
                    count <= count + 1'b1;
                else if (!issue_fire && commit_fire)
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed issue/writeback sequences push
// expected commit events; a negedge monitor pops and compares them.
module tb_reorder_buffer;

    localparam int ROB_W = 4;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             issue_valid;
    logic [1:0]       issue_type;
    logic [4:0]       issue_rd;
    logic             issue_pred_taken;
    logic [31:0]      issue_alt_pc;
    logic             rob_full;
    logic [ROB_W-1:0] issue_rob_id;
    logic             need_set_reg_dep;
    logic [4:0]       set_dep_reg_id;
    logic [ROB_W-1:0] set_dep_rob_id;
    logic             alu_wb_valid;
    logic [ROB_W-1:0] alu_wb_rob_id;
    logic [31:0]      alu_wb_value;
    logic             alu_wb_taken;
    logic             lsb_wb_valid;
    logic [ROB_W-1:0] lsb_wb_rob_id;
    logic [31:0]      lsb_wb_value;
    logic [ROB_W-1:0] need_rob_id1;
    logic [ROB_W-1:0] need_rob_id2;
    logic             rob_value1_ready;
    logic             rob_value2_ready;
    logic [31:0]      rob_value1;
    logic [31:0]      rob_value2;
    logic             need_set_reg_value;
    logic [4:0]       set_value_reg_id;
    logic [31:0]      set_val;
    logic [ROB_W-1:0] set_reg_rob_id;
    logic             store_commit;
    logic [ROB_W-1:0] store_commit_rob_id;
    logic             clear;
    logic [31:0]      clear_pc;

    reorder_buffer #(.ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .rob_full(rob_full), .issue_rob_id(issue_rob_id),
        .need_set_reg_dep(need_set_reg_dep), .set_dep_reg_id(set_dep_reg_id),
        .set_dep_rob_id(set_dep_rob_id),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rob_id(alu_wb_rob_id),
        .alu_wb_value(alu_wb_value), .alu_wb_taken(alu_wb_taken),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_rob_id(lsb_wb_rob_id),
        .lsb_wb_value(lsb_wb_value),
        .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
        .set_val(set_val), .set_reg_rob_id(set_reg_rob_id),
        .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id),
        .clear(clear), .clear_pc(clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event word: {reg_write, store, clear, rd, value_or_pc, rob_id}
    typedef logic [43:0] obs_t;
    obs_t expq[$];
    obs_t obs;
    obs_t exp_ev;
    int checks = 0;
    int errors = 0;

    function automatic obs_t mkReg(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        return {3'b100, rd, v, id};
    endfunction

    function automatic obs_t mkStore(input logic [3:0] id);
        return {3'b010, 5'd0, 32'd0, id};
    endfunction

    function automatic obs_t mkClear(input logic [31:0] pc);
        return {3'b001, 5'd0, pc, 4'd0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every commit/store/clear pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (need_set_reg_value || store_commit || clear)) begin
            obs = {need_set_reg_value, store_commit, clear,
                   need_set_reg_value ? set_value_reg_id : 5'd0,
                   need_set_reg_value ? set_val : (clear ? clear_pc : 32'd0),
                   need_set_reg_value ? set_reg_rob_id :
                       (store_commit ? store_commit_rob_id : 4'd0)};
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got 0x%0h expected none", obs);
            end else begin
                exp_ev = expq.pop_front();
                if (obs !== exp_ev) begin
                    errors++;
                    $display("[TB] FAIL commit_event: got 0x%0h expected 0x%0h", obs, exp_ev);
                end
            end
        end
    end

    task automatic idleInputs();
        issue_valid      = 1'b0;
        issue_type       = 2'd0;
        issue_rd         = 5'd0;
        issue_pred_taken = 1'b0;
        issue_alt_pc     = 32'd0;
        alu_wb_valid     = 1'b0;
        alu_wb_rob_id    = '0;
        alu_wb_value     = 32'd0;
        alu_wb_taken     = 1'b0;
        lsb_wb_valid     = 1'b0;
        lsb_wb_rob_id    = '0;
        lsb_wb_value     = 32'd0;
    endtask

    // Let the current inputs be sampled, then return mid-cycle with idle inputs.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
        #1;
        idleInputs();
    endtask

    task automatic doIssue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                           input logic [31:0] pc, input logic [3:0] exp_id, input logic accept);
        issue_valid      = 1'b1;
        issue_type       = t;
        issue_rd         = rd;
        issue_pred_taken = pred;
        issue_alt_pc     = pc;
        #1;
        checkOutput("need_set_reg_dep", need_set_reg_dep, accept && (rd != 5'd0));
        if (accept) begin
            checkOutput("issue_rob_id", issue_rob_id, exp_id);
            checkOutput("set_dep_rob_id", set_dep_rob_id, exp_id);
            checkOutput("set_dep_reg_id", set_dep_reg_id, rd);
        end
        applyStimulus();
    endtask

    task automatic wbAlu(input logic [3:0] id, input logic [31:0] v, input logic tk);
        alu_wb_valid  = 1'b1;
        alu_wb_rob_id = id;
        alu_wb_value  = v;
        alu_wb_taken  = tk;
    endtask

    task automatic wbLsb(input logic [3:0] id, input logic [31:0] v);
        lsb_wb_valid  = 1'b1;
        lsb_wb_rob_id = id;
        lsb_wb_value  = v;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] id;
        rst = 1'b1;
        rdy = 1'b1;
        need_rob_id1 = '0;
        need_rob_id2 = '0;
        idleInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_rob_full", rob_full, 0);
        checkOutput("reset_reg_write", need_set_reg_value, 0);
        checkOutput("reset_store", store_commit, 0);
        checkOutput("reset_clear", clear, 0);
        checkOutput("reset_query", rob_value1_ready, 0);

        doIssue(2'd0, 5'd1, 1'b0, 32'd0, 4'd0, 1'b1);
        doIssue(2'd0, 5'd2, 1'b0, 32'd0, 4'd1, 1'b1);
        doIssue(2'd0, 5'd3, 1'b0, 32'd0, 4'd2, 1'b1);

        // Younger result first must not commit anything.
        wbAlu(4'd1, 32'h55, 1'b0);
        applyStimulus();
        need_rob_id1 = 4'd1;
        #1;
        checkOutput("query_stored_ready", rob_value1_ready, 1);
        checkOutput("query_stored_value", rob_value1, 32'h55);
        applyStimulus();

        expq.push_back(mkReg(5'd1, 32'h11, 4'd0));
        expq.push_back(mkReg(5'd2, 32'h55, 4'd1));
        wbAlu(4'd0, 32'h11, 1'b0);
        repeat (4) applyStimulus();

        need_rob_id1 = 4'd2;
        #1;
        checkOutput("query_pending_ready", rob_value1_ready, 0);
        checkOutput("query_pending_value", rob_value1, 0);
        wbAlu(4'd2, 32'h77, 1'b0);
        #1;
        checkOutput("query_bypass_ready", rob_value1_ready, 1);
        checkOutput("query_bypass_value", rob_value1, 32'h77);
        expq.push_back(mkReg(5'd3, 32'h77, 4'd2));
        applyStimulus();
        repeat (3) applyStimulus();

        // Fill all 16 entries starting at id 3.
        for (int i = 0; i < 16; i++) begin
            id = 4'(3 + i);
            doIssue(2'd0, 5'd4, 1'b0, 32'd0, id, 1'b1);
        end
        checkOutput("full_after_16", rob_full, 1);
        doIssue(2'd0, 5'd4, 1'b0, 32'd0, 4'd0, 1'b0);

        expq.push_back(mkReg(5'd4, 32'hA3, 4'd3));
        wbAlu(4'd3, 32'hA3, 1'b0);
        applyStimulus();
        // Head commits on this edge, but the registered count still says full.
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        #1;
        checkOutput("full_during_commit", rob_full, 1);
        checkOutput("no_dep_during_commit", need_set_reg_dep, 0);
        applyStimulus();
        checkOutput("not_full_after_commit", rob_full, 0);
        doIssue(2'd0, 5'd9, 1'b0, 32'd0, 4'd3, 1'b1);
        checkOutput("full_after_wrap", rob_full, 1);

        for (int k = 0; k < 16; k++) begin
            id = 4'(4 + k);
            expq.push_back(mkReg((k == 15) ? 5'd9 : 5'd4, 32'h100 + 32'(id), id));
            if (k % 2 == 1) wbLsb(id, 32'h100 + 32'(id));
            else            wbAlu(id, 32'h100 + 32'(id), 1'b0);
            applyStimulus();
        end
        repeat (4) applyStimulus();

        // Mispredicted branch at id 4 with two completed younger entries.
        doIssue(2'd3, 5'd0, 1'b0, 32'h1000, 4'd4, 1'b1);
        doIssue(2'd0, 5'd5, 1'b0, 32'd0, 4'd5, 1'b1);
        doIssue(2'd0, 5'd6, 1'b0, 32'd0, 4'd6, 1'b1);
        wbAlu(4'd5, 32'h5, 1'b0);
        applyStimulus();
        expq.push_back(mkClear(32'h1000));
        wbAlu(4'd4, 32'h0, 1'b1);
        wbLsb(4'd6, 32'h6);
        applyStimulus();
        applyStimulus();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        wbAlu(4'd0, 32'hDEAD, 1'b0);
        need_rob_id1 = 4'd5;
        #1;
        checkOutput("clear_high", clear, 1);
        checkOutput("full_during_clear", rob_full, 1);
        checkOutput("no_dep_during_clear", need_set_reg_dep, 0);
        checkOutput("flushed_query", rob_value1_ready, 0);
        applyStimulus();
        checkOutput("clear_dropped", clear, 0);
        checkOutput("empty_after_clear", rob_full, 0);

        doIssue(2'd2, 5'd0, 1'b0, 32'd0, 4'd0, 1'b1);
        doIssue(2'd0, 5'd0, 1'b0, 32'd0, 4'd1, 1'b1);
        doIssue(2'd3, 5'd0, 1'b1, 32'h2000, 4'd2, 1'b1);
        need_rob_id2 = 4'd0;
        wbLsb(4'd0, 32'h33);
        #1;
        checkOutput("lsb_bypass_ready", rob_value2_ready, 1);
        checkOutput("lsb_bypass_value", rob_value2, 32'h33);
        expq.push_back(mkStore(4'd0));
        applyStimulus();
        wbAlu(4'd1, 32'h99, 1'b0);
        applyStimulus();
        wbAlu(4'd2, 32'h0, 1'b1);
        repeat (5) applyStimulus();

        // Stall: writeback and issue presented with rdy low are dropped.
        doIssue(2'd0, 5'd7, 1'b0, 32'd0, 4'd3, 1'b1);
        rdy = 1'b0;
        wbAlu(4'd3, 32'h42, 1'b0);
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        applyStimulus();
        wbAlu(4'd3, 32'h42, 1'b0);
        applyStimulus();
        rdy = 1'b1;
        need_rob_id1 = 4'd3;
        #1;
        checkOutput("stall_wb_ignored", rob_value1_ready, 0);
        checkOutput("stall_issue_ignored", issue_rob_id, 4'd4);
        expq.push_back(mkReg(5'd7, 32'h42, 4'd3));
        wbAlu(4'd3, 32'h42, 1'b0);
        repeat (5) applyStimulus();

        checkOutput("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
